// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between a read-only fetch
// port (F) and a read/write data port (D).
//
// Arbitration is round-robin, with one transaction in flight at a time.
// Addresses are bounds-checked. An out-of-bounds access is answered with err
// and never reaches the memory.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   f_req/f_addr                    fetch read request
//   f_gnt/f_rvalid/f_rdata/f_err    fetch grant and response
//   d_req/d_we/d_addr/d_wdata       data request
//   d_gnt/d_rvalid/d_rdata/d_err    data grant and response/write-ack
//   mem_en/mem_we/mem_addr/mem_wdata  memory command (ACCESS state only)
//   mem_rdata                       memory read data, valid the cycle after mem_en
//   busy                            FSM not IDLE
//
// Timing: gnt at T, memory access at T+1, rvalid at T+2, next gnt at T+3 or later.
// gnt is combinational from req, so a requester sees it in the same cycle.
// The remaining outputs decode from registered state, so they drop to 0 as
// soon as reset is asserted.
module dmem_arbiter #(
  parameter int unsigned MEM_SIZE = 512,
  parameter int unsigned DATA_W   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [63:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [63:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [63:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned ADDR_W = 64;
  // Highest legal word start address; compared on all 64 bits so that no wrap occurs.
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_SIZE - 8);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t              state_q, state_d;
  owner_t              last_owner_q, owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q;
  logic                sel_f, sel_d;
  logic                err;
  logic [DATA_W-1:0]   resp_data;

  assign err = (addr_q > MAX_ADDR);

  // State register and request latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_F;
      owner_q      <= OWN_F;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (sel_d) begin
        addr_q       <= d_addr;
        wdata_q      <= d_wdata;
        we_q         <= d_we;
        owner_q      <= OWN_D;
        last_owner_q <= OWN_D;
      end else if (sel_f) begin
        addr_q       <= f_addr;
        wdata_q      <= '0;
        we_q         <= 1'b0;
        owner_q      <= OWN_F;
        last_owner_q <= OWN_F;
      end
    end
  end

  // Next-state, arbitration and output decode
  always_comb begin
    state_d   = state_q;
    sel_f     = 1'b0;
    sel_d     = 1'b0;
    f_gnt     = 1'b0;
    d_gnt     = 1'b0;
    f_rvalid  = 1'b0;
    f_rdata   = '0;
    f_err     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    d_err     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    resp_data = '0;
    busy      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        // On a tie the port that did not own the last transaction wins.
        // rst_n gating keeps gnt low while reset is held.
        if (rst_n) begin
          if (f_req && d_req) begin
            sel_d = (last_owner_q == OWN_F);
            sel_f = ~sel_d;
          end else begin
            sel_f = f_req;
            sel_d = d_req;
          end
        end
        f_gnt = sel_f;
        d_gnt = sel_d;
        if (sel_f || sel_d) state_d = ACCESS;
      end

      ACCESS: begin
        if (!err) begin
          mem_en    = 1'b1;
          mem_we    = we_q;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
        end
        state_d = RESP;
      end

      RESP: begin
        if (!err && !we_q) resp_data = mem_rdata;
        if (owner_q == OWN_D) begin
          d_rvalid = 1'b1;
          d_err    = err;
          d_rdata  = resp_data;
        end else begin
          f_rvalid = 1'b1;
          f_err    = err;
          f_rdata  = resp_data;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter.
// The driver pushes the expected response and memory access when a grant is
// seen. The monitor pops and compares them whenever rvalid or mem_en appears.
module tb_dmem_arbiter;

  localparam int unsigned MEM_SIZE = 512;
  localparam int unsigned DATA_W   = 64;
  localparam logic [63:0] PAT_A5   = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] PAT_HI   = 64'h1122_3344_5566_7788;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              f_req = 1'b0;
  logic [63:0]       f_addr = '0;
  logic              f_gnt, f_rvalid, f_err;
  logic [DATA_W-1:0] f_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [63:0]       d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_gnt, d_rvalid, d_err;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en, mem_we;
  logic [63:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              busy;

  dmem_arbiter #(.MEM_SIZE(MEM_SIZE), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte-addressed little-endian memory with one-cycle read latency
  logic [7:0] mem_arr [MEM_SIZE];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int k = 0; k < 8; k++) begin
        if (int'(mem_addr[8:0]) + k < int'(MEM_SIZE)) begin
          if (mem_we) mem_arr[int'(mem_addr[8:0]) + k] <= mem_wdata[8*k +: 8];
          else        mem_rdata[8*k +: 8] <= mem_arr[int'(mem_addr[8:0]) + k];
        end
      end
    end
  end

  typedef struct {
    bit          port;   // 1 = D, 0 = F
    bit          err;
    logic [63:0] rdata;
    int          due;
  } resp_t;

  typedef struct {
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          due;
  } acc_t;

  resp_t resp_q[$];
  acc_t  acc_q[$];
  resp_t er;
  acc_t  ea;
  int    n_cmp = 0;
  int    n_bad = 0;

  logic [8:0]  ctl;
  logic [63:0] dat;
  assign ctl = {f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err, mem_en, mem_we, busy};
  assign dat = f_rdata | d_rdata | mem_addr | mem_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_txn(input bit port, input bit we, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [63:0] rdata,
                            input bit err, input int t);
    resp_t r;
    acc_t  a;
    r.port = port; r.err = err; r.rdata = rdata; r.due = t + 2;
    resp_q.push_back(r);
    if (!err) begin
      a.we = we; a.addr = addr; a.wdata = wdata; a.due = t + 1;
      acc_q.push_back(a);
    end
  endtask

  // Waits for the port's grant; t is the grant cycle, or -1 on timeout
  task automatic wait_gnt(input bit port, output int t);
    int n;
    t = -1;
    n = 0;
    while (n < 20 && t < 0) begin
      @(negedge clk);
      if (port ? d_gnt : f_gnt) t = cyc;
      n++;
    end
    if (t < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL gnt_timeout: port %0d got no grant within 20 cycles", port);
    end
  endtask

  task automatic do_req(input bit port, input bit we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdata, input bit err);
    int t;
    @(posedge clk); #1;
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    wait_gnt(port, t);
    if (t >= 0) expect_txn(port, port ? we : 1'b0, addr, wdata, rdata, err, t);
    @(posedge clk); #1;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  // Monitor: compare each presented response or memory access against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (f_gnt || d_gnt || f_rvalid || d_rvalid)
        check("onehot", 64'({f_gnt & d_gnt, f_rvalid & d_rvalid}), 64'd0);
      if (f_rvalid || d_rvalid) begin
        if (resp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rvalid: f_rvalid=%0b d_rvalid=%0b required none (cycle %0d)",
                   f_rvalid, d_rvalid, cyc);
        end else begin
          er = resp_q.pop_front();
          check("resp_port", 64'(d_rvalid), 64'(er.port));
          check("resp_err", 64'(er.port ? d_err : f_err), 64'(er.err));
          check("resp_rdata", er.port ? d_rdata : f_rdata, er.rdata);
          check("resp_cycle", 64'(cyc), 64'(er.due));
          check("resp_other_quiet", 64'(er.port ? (f_rdata | 64'(f_err)) : (d_rdata | 64'(d_err))), 64'd0);
        end
      end
      if (mem_en) begin
        if (acc_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_mem_en: addr=0x%0h we=%0b required no access (cycle %0d)",
                   mem_addr, mem_we, cyc);
        end else begin
          ea = acc_q.pop_front();
          check("mem_we", 64'(mem_we), 64'(ea.we));
          check("mem_addr", mem_addr, ea.addr);
          if (ea.we) check("mem_wdata", mem_wdata, ea.wdata);
          check("mem_cycle", 64'(cyc), 64'(ea.due));
        end
      end
    end
  end

  initial begin
    int t, t2, prev, got, n;
    bit exp_port;

    for (int i = 0; i < int'(MEM_SIZE); i++) mem_arr[i] = 8'h00;

    // Reset held for two cycles, then idle with no requests
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ctl", 64'(ctl), 64'd0);
    check("reset_data", dat, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ctl", 64'(ctl), 64'd0);
      check("idle_data", dat, 64'd0);
    end

    // Directed transactions: write/read, bounds and unaligned access
    do_req(1'b1, 1'b1, 64'd0,   PAT_A5, 64'd0,  1'b0);
    do_req(1'b1, 1'b0, 64'd0,   64'd0,  PAT_A5, 1'b0);
    do_req(1'b1, 1'b1, 64'd504, PAT_HI, 64'd0,  1'b0);
    do_req(1'b1, 1'b0, 64'd504, 64'd0,  PAT_HI, 1'b0);
    do_req(1'b1, 1'b1, 64'd512, 64'hDEAD_BEEF, 64'd0, 1'b1);
    do_req(1'b1, 1'b0, 64'd505, 64'd0,  64'd0,  1'b1);
    do_req(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, 1'b1);
    do_req(1'b0, 1'b0, 64'd513, 64'd0,  64'd0,  1'b1);
    do_req(1'b0, 1'b0, 64'd0,   64'd0,  PAT_A5, 1'b0);
    do_req(1'b1, 1'b0, 64'd3,   64'd0,  64'h0000_00A5_A5A5_A5A5, 1'b0);
    do_req(1'b1, 1'b0, 64'd504, 64'd0,  PAT_HI, 1'b0);

    // A late F request during D ACCESS waits for IDLE; the D request is dropped right after gnt
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd0;
    wait_gnt(1'b1, t);
    if (t >= 0) expect_txn(1'b1, 1'b0, 64'd0, 64'd0, PAT_A5, 1'b0, t);
    @(posedge clk); #1;
    d_req = 1'b0; f_req = 1'b1; f_addr = 64'd0;
    wait_gnt(1'b0, t2);
    check("late_f_gnt_cycle", 64'(t2 - t), 64'd3);
    if (t2 >= 0) expect_txn(1'b0, 1'b0, 64'd0, 64'd0, PAT_A5, 1'b0, t2);
    @(posedge clk); #1 f_req = 1'b0;
    repeat (4) @(posedge clk);

    // Reset while a D read is in ACCESS: outputs drop at once and no rvalid follows
    #1 d_req = 1'b1; d_we = 1'b0; d_addr = 64'd0;
    wait_gnt(1'b1, t);
    @(posedge clk); #1 d_req = 1'b0;
    check("mid_busy", 64'(busy), 64'd1);
    check("mid_mem_en", 64'(mem_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_ctl", 64'(ctl), 64'd0);
    check("mid_reset_data", dat, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_rvalid", 64'({f_rvalid, d_rvalid}), 64'd0);
    end

    // Contention from reset: both ports hold req for four grants, D first, 3 cycles apart
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 64'd0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd504;
    exp_port = 1'b1;
    prev = -1;
    got = 0;
    n = 0;
    while (got < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (f_gnt || d_gnt) begin
        check("cont_order", 64'(d_gnt), 64'(exp_port));
        if (prev >= 0) check("cont_spacing", 64'(cyc - prev), 64'd3);
        prev = cyc;
        if (d_gnt) expect_txn(1'b1, 1'b0, 64'd504, 64'd0, PAT_HI, 1'b0, cyc);
        else       expect_txn(1'b0, 1'b0, 64'd0,   64'd0, PAT_A5, 1'b0, cyc);
        exp_port = ~exp_port;
        got++;
      end
    end
    if (got < 4) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cont_timeout: got %0d grants, required 4", got);
    end
    @(posedge clk); #1;
    f_req = 1'b0; d_req = 1'b0;

    // Drain: every expected response and access must have appeared
    repeat (6) @(negedge clk);
    check("drain_resp", 64'(resp_q.size()), 64'd0);
    check("drain_acc", 64'(acc_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (MEM_SIZE bytes, byte-addressed, 64-bit little-endian words) between two requesters: fetch port F (read-only) and data port D (read/write, driven by the memory stage for rmmovq/mrmovq/call/ret/pushq/popq).
- Round-robin arbitration and address bounds checking; one transaction in flight at a time.
- Per-port req/gnt/rvalid handshake; error responses are returned without touching memory.

Parameters:
MEM_SIZE, 512, memory size in bytes; a legal word access satisfies addr <= MEM_SIZE-8
DATA_W, 64, word width in bits

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
f_req  input  1  fetch port requests a read
f_addr  input  64  fetch byte address
f_gnt  output  1  fetch request accepted this cycle
f_rvalid  output  1  fetch response valid, one-cycle pulse
f_rdata  output  DATA_W  fetch read data
f_err  output  1  fetch out-of-bounds, qualified by f_rvalid
d_req  input  1  data port request
d_we  input  1  1 = write, 0 = read
d_addr  input  64  data byte address
d_wdata  input  DATA_W  write data
d_gnt  output  1  data request accepted this cycle
d_rvalid  output  1  data response or write-ack, one-cycle pulse
d_rdata  output  DATA_W  read data; 0 on writes and errors
d_err  output  1  data out-of-bounds, qualified by d_rvalid
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  64  memory byte address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en
busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE, last_owner=F.
  - All outputs 0; latched addr, wdata, we and owner cleared.
  - Any in-flight transaction is dropped; no rvalid is ever issued for it.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If exactly one req is high, that port is selected.
  - If both are high, select the port that is not last_owner. The reset value of last_owner is F, so D wins the first tie.
  - The selected port's gnt is driven combinationally high in that cycle. The requester must hold addr/we/wdata valid during its gnt cycle.
  - On the edge: latch addr, we (forced 0 for F), wdata and owner; update last_owner; go to ACCESS.
  - With no req, stay in IDLE.
- ACCESS:
  - Error condition: err_lat = (addr > MEM_SIZE-8). Compare on the full 64 bits with no addr+8 overflow wrap; for example, 0xFFFF_FFFF_FFFF_FFFC is an error.
  - If err_lat: mem_en=0.
  - Otherwise: mem_en=1, mem_we=we, mem_addr=latched addr, mem_wdata=latched wdata.
  - Go to RESP unconditionally.
- RESP:
  - Owner's rvalid=1 and err=err_lat.
  - rdata = mem_rdata for a successful read, otherwise 0.
  - The non-owner's rvalid, rdata and err are 0.
  - Go to IDLE.
- Timing:
  - Gnt at cycle T, memory access at T+1, rvalid at T+2.
  - Next gnt no earlier than T+3. Peak throughput is 1 transaction per 3 cycles.
- gnt is 0 in ACCESS and RESP. req asserted there is ignored and re-arbitrated in IDLE; requesters hold req until gnt.
- Deasserting req after gnt does not cancel the transaction; the response is still delivered.
- Unaligned addresses are legal (for example 0x3); alignment is the memory's concern.
- At most one of f_gnt/d_gnt and one of f_rvalid/d_rvalid is high in any cycle.
- mem_en and mem_we are 0 outside ACCESS.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then release with no req -> all outputs 0, busy=0, mem_en never asserted.
- D write then read:
  - D write addr=0, wdata=0xA5A5A5A5A5A5A5A5 -> d_gnt@T, mem_en=mem_we=1 @T+1, d_rvalid=1, d_err=0, d_rdata=0 @T+2.
  - D read addr=0 -> d_rdata=0xA5A5A5A5A5A5A5A5.
- Bounds:
  - D write addr=512 -> d_err=1 with no mem_en.
  - addr=504 -> ok.
  - addr=505 -> err.
  - addr=0xFFFF_FFFF_FFFF_FFFC -> err.
  - F read addr=513 -> f_err=1.
- Contention: f_req and d_req held high for 4 transactions out of reset -> grant order D,F,D,F with gnts 3 cycles apart; each rdata returns to the correct port.
- Late and withdrawn requests:
  - f_req rises during ACCESS of a D transaction -> f_gnt waits until IDLE.
  - d_req dropped right after d_gnt -> d_rvalid still pulses.
- Reset mid-operation: assert rst_n=0 in ACCESS -> outputs 0 immediately, no rvalid after release, next arbitration favours D.
